// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the single-cycle MIPS core.
//
// This block owns the program counter. It reads one word from instruction memory over a
// req/ack handshake. It then holds that word for decode/execute behind a valid/ready
// handshake. When the instruction retires, it loads the next PC supplied by the npc block.
//
// Parameters:
//   RESET_PC   - value loaded into pc on reset
//   TIMEOUT    - max request cycles without ack before a bus error (2..255)
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   npc                      - next PC from npc block, sampled on the retire edge
//   npc_t                    - pc + 4 (combinational)
//   pc                       - current PC register
//   imem_req/imem_addr       - instruction memory read request / address (= pc)
//   imem_ack/imem_rdata      - read data valid / instruction word
//   instr/instr_valid        - registered instruction and its valid flag
//   instr_ready              - consumer retires instr this cycle
//   halted                   - syscall retired, fetch stopped
//   err/err_code             - sticky error flag; 01 fetch timeout, 10 misaligned npc
//
// Configuration macro:
//   IFU_ALIGN_CHECK_EN - when defined, retiring with npc[1:0] != 0 raises err_code 10.
//                        When undefined, the low npc bits are dropped.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] npc_t,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {StIdle, StReq, StValid, StHalt, StErr} state_e;

  localparam logic [7:0]  CntLast      = 8'(TIMEOUT - 1);
  localparam logic [31:0] InstrSyscall = 32'h0000_000C;
  localparam logic [1:0]  ErrTimeout   = 2'b01;
  localparam logic [1:0]  ErrAlign     = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        npc_bad;
  logic [31:0] npc_next;

`ifdef IFU_ALIGN_CHECK_EN
  assign npc_bad  = |npc[1:0];
  assign npc_next = npc;
`else
  // Misaligned targets are silently forced onto a word boundary.
  assign npc_bad  = 1'b0;
  assign npc_next = npc & ~32'h3;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    err_code_d  = err_code_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        state_d = StReq;
      end
      StReq: begin
        imem_req = 1'b1;
        // Ack wins over a timeout landing on the same cycle.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StValid;
        end else if (cnt_q == CntLast) begin
          err_code_d = ErrTimeout;
          state_d    = StErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StValid: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          if (instr_q == InstrSyscall) begin
            state_d = StHalt;
          end else if (npc_bad) begin
            // pc keeps the retiring instruction's address for post-mortem.
            err_code_d = ErrAlign;
            state_d    = StErr;
          end else begin
            pc_d    = npc_next;
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StHalt: halted = 1'b1;
      StErr:  err    = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      cnt_q      <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign npc_t     = pc_q + 32'd4;
  assign instr     = instr_q;
  assign err_code  = err_code_q;

endmodule
